// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader.
// Sync byte, FSM encodings and bit-timing derivation.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_RESTART,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling,
// one-cycle byte_valid or frame_err per frame.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CPB = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

  logic            s1_q, s2_q, prev_q;
  rx_state_e       st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            bv_q, bv_d;
  logic            fe_q, fe_d;
  logic            tick, half;

  assign tick = (cnt_q == FULL);
  assign half = (cnt_q == HALF);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      st_q   <= RX_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      bv_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      bv_q   <= bv_d;
      fe_q   <= fe_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d  = sh_q;
    bv_d  = 1'b0;
    fe_d  = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !s2_q) st_d = RX_START;
      end
      RX_START: begin
        // a start bit that is high again at mid-bit is a glitch
        if (half) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tick) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick) begin
          cnt_d = '0;
          st_d  = RX_IDLE;
          bv_d  = s2_q;
          fe_d  = !s2_q;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign rx_data_o    = sh_q;
  assign byte_valid_o = bv_q;
  assign frame_err_o  = fe_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: streams a UART program image into instruction
// memory, stalls the core meanwhile, then pulses core reset.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RX,
  output logic              IMEM_WE,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic [31:0]       IMEM_WDATA,
  output logic              CPU_EN,
  output logic              CPU_RESET,
  output logic              BUSY,
  output logic              ERROR
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  logic [7:0] rx_data;
  logic       byte_valid;
  logic       frame_err;

  uart_rx #(
    .CPB(CPB)
  ) u_rx (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .rx_i        (RX),
    .rx_data_o   (rx_data),
    .byte_valid_o(byte_valid),
    .frame_err_o (frame_err)
  );

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [ADDR_W:0]   widx_inc;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       n;
  logic              sync_hit;

  assign widx_inc = widx_q + 1'b1;
  assign sync_hit = byte_valid && (rx_data == SYNC_BYTE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      len_lo_q <= '0;
      len_q    <= '0;
      widx_q   <= '0;
      bidx_q   <= '0;
      word_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      widx_q   <= widx_d;
      bidx_q   <= bidx_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    widx_d   = widx_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    n        = {rx_data, len_lo_q};
    unique case (state_q)
      ST_IDLE: begin
        if (sync_hit) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (frame_err) begin
          state_d = ST_ERR;
        end else if (byte_valid) begin
          len_lo_d = rx_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (frame_err) begin
          state_d = ST_ERR;
        end else if (byte_valid) begin
          if (n == 16'd0) begin
            state_d = ST_RESTART;
          end else if ({1'b0, n} > CAP) begin
            state_d = ST_ERR;
          end else begin
            len_d   = n[ADDR_W:0];
            widx_d  = '0;
            bidx_d  = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (frame_err) begin
          state_d = ST_ERR;
        end else if (byte_valid) begin
          bidx_d = bidx_q + 1'b1;
          unique case (bidx_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            2'd3: begin
              addr_d  = widx_q[ADDR_W-1:0];
              wdata_d = {rx_data, word_q};
              state_d = ST_WRITE;
            end
            default: ;
          endcase
        end
      end
      ST_WRITE: begin
        widx_d  = widx_inc;
        state_d = (widx_inc == len_q) ? ST_RESTART : ST_DATA;
      end
      ST_RESTART: state_d = ST_IDLE;
      ST_ERR: begin
        if (sync_hit) state_d = ST_LEN_LO;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs decode straight from the registered state
  assign IMEM_WE    = (state_q == ST_WRITE);
  assign IMEM_ADDR  = addr_q;
  assign IMEM_WDATA = wdata_q;
  assign CPU_EN     = (state_q == ST_IDLE);
  assign CPU_RESET  = (state_q == ST_RESTART);
  assign ERROR      = (state_q == ST_ERR);
  assign BUSY       = !(state_q == ST_IDLE || state_q == ST_ERR);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed UART frames, expected
// memory writes and core resets checked by a queue-driven monitor.
module tb_uart_prog_loader;

  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          RX = 1'b1;
  logic          IMEM_WE;
  logic [AW-1:0] IMEM_ADDR;
  logic [31:0]   IMEM_WDATA;
  logic          CPU_EN;
  logic          CPU_RESET;
  logic          BUSY;
  logic          ERROR;

  uart_prog_loader #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000),
    .ADDR_W  (AW)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .RX        (RX),
    .IMEM_WE   (IMEM_WE),
    .IMEM_ADDR (IMEM_ADDR),
    .IMEM_WDATA(IMEM_WDATA),
    .CPU_EN    (CPU_EN),
    .CPU_RESET (CPU_RESET),
    .BUSY      (BUSY),
    .ERROR     (ERROR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_rst;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  bit prev_rst = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    e.is_rst = 1'b0;
    e.addr   = a;
    e.data   = d;
    sb.push_back(e);
  endtask

  task automatic push_rst();
    exp_t e;
    e.is_rst = 1'b1;
    e.addr   = '0;
    e.data   = '0;
    sb.push_back(e);
  endtask

  // monitor: every write strobe / core reset must match the queue head
  always @(negedge CLK) begin
    exp_t e;
    if (prev_rst) chk("cpu_en_after_rst", {31'd0, CPU_EN}, 32'd1);
    prev_rst = CPU_RESET;
    if (IMEM_WE) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_we: addr %h data %h, expected none",
                 IMEM_ADDR, IMEM_WDATA);
      end else begin
        e = sb.pop_front();
        chk("ev_kind_we", {31'd0, e.is_rst}, 32'd0);
        chk("we_addr", {28'd0, IMEM_ADDR}, {28'd0, e.addr});
        chk("we_data", IMEM_WDATA, e.data);
        chk("we_cpu_en", {31'd0, CPU_EN}, 32'd0);
      end
    end
    if (CPU_RESET) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_cpu_reset: got pulse, expected none");
      end else begin
        e = sb.pop_front();
        chk("ev_kind_rst", {31'd0, e.is_rst}, 32'd1);
        chk("rst_cpu_en", {31'd0, CPU_EN}, 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
    @(negedge CLK);
    RX = 1'b0;
    repeat (10) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (10) @(negedge CLK);
    end
    RX = stop;
    repeat (10) @(negedge CLK);
    RX = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic chk_flags(input string tag, input bit en,
                           input bit busy, input bit err);
    chk({tag, "_cpu_en"}, {31'd0, CPU_EN}, {31'd0, en});
    chk({tag, "_busy"}, {31'd0, BUSY}, {31'd0, busy});
    chk({tag, "_error"}, {31'd0, ERROR}, {31'd0, err});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, {31'd0, IMEM_WE}, 32'd0);
    chk({tag, "_addr"}, {28'd0, IMEM_ADDR}, 32'd0);
    chk({tag, "_wdata"}, IMEM_WDATA, 32'd0);
    chk({tag, "_cpu_rst"}, {31'd0, CPU_RESET}, 32'd0);
    chk_flags(tag, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_sb_left"}, sb.size(), 32'd0);
  endtask

  task automatic nominal(input string tag);
    push_wr(4'd0, 32'h0050_0513);
    push_wr(4'd1, 32'h00A0_0593);
    push_rst();
    send_byte(8'hA5);
    chk_flags({tag, "_sync"}, 1'b0, 1'b1, 1'b0);
    send_seq('{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
               8'h93, 8'h05, 8'hA0, 8'h00});
    repeat (5) @(negedge CLK);
    chk_flags({tag, "_done"}, 1'b1, 1'b0, 1'b0);
    chk_drained(tag);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk_reset_vals("por");

    nominal("nom");

    push_rst();
    send_seq('{8'hA5, 8'h00, 8'h00});
    repeat (5) @(negedge CLK);
    chk_flags("zero", 1'b1, 1'b0, 1'b0);
    chk_drained("zero");

    send_seq('{8'hA5, 8'h11, 8'h00});
    repeat (3) @(negedge CLK);
    chk_flags("over", 1'b0, 1'b0, 1'b1);
    nominal("over_rec");

    send_seq('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05});
    send_byte(8'h50, 1'b0);
    repeat (3) @(negedge CLK);
    chk_flags("ferr", 1'b0, 1'b0, 1'b1);
    send_seq('{8'h00, 8'h93, 8'h05, 8'hA0, 8'h00});
    chk_flags("ferr_hold", 1'b0, 1'b0, 1'b1);
    chk_drained("ferr");
    push_rst();
    send_seq('{8'hA5, 8'h00, 8'h00});
    repeat (5) @(negedge CLK);
    chk_flags("ferr_rec", 1'b1, 1'b0, 1'b0);
    chk_drained("ferr_rec");

    RX = 1'b0;
    repeat (3) @(negedge CLK);
    RX = 1'b1;
    repeat (20) @(negedge CLK);
    send_seq('{8'h00, 8'hFF});
    repeat (5) @(negedge CLK);
    chk_flags("noise", 1'b1, 1'b0, 1'b0);
    chk_drained("noise");

    push_wr(4'd0, 32'h0050_0513);
    send_seq('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
               8'h93});
    chk_flags("mid", 1'b0, 1'b1, 1'b0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk_reset_vals("mid_rst");
    chk_drained("mid");

    push_wr(4'd0, 32'hDEAD_BEEF);
    push_rst();
    send_seq('{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    repeat (5) @(negedge CLK);
    chk_flags("fresh", 1'b1, 1'b0, 1'b0);
    chk_drained("fresh");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Upstream boot stage for the single-cycle RISC-V core. Receives a program image over a UART RX line and writes it word-by-word into instruction memory. Holds the core stalled (EN low) during the load, then pulses a core reset so execution restarts at address 0. Sits between the board UART pin and the instruction-memory write port / core EN and RESET inputs.

## Interface
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD, 115200: UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be ≥ 4).
- ADDR_W, 8: instruction-memory word-address width; capacity 2^ADDR_W words.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  synchronous, active-high.
- RX  in  1  asynchronous UART line, idle high.
- IMEM_WE  out  1  one-cycle write strobe to instruction memory.
- IMEM_ADDR  out  ADDR_W  word address of the write.
- IMEM_WDATA  out  32  write data.
- CPU_EN  out  1  drives core EN; 0 while loading or in error.
- CPU_RESET  out  1  one-cycle reset pulse to the core after a successful load.
- BUSY  out  1  load in progress.
- ERROR  out  1  sticky load failure.

## Operation
- Reset values: IMEM_WE=0, IMEM_ADDR=0, IMEM_WDATA=0, CPU_EN=1, CPU_RESET=0, BUSY=0, ERROR=0. State IDLE.
- Protocol: sync byte 0xA5, word count N (2 bytes, LSB first), then N words of 4 bytes each, LSB first.
- UART receiver:
  - RX passes through a 2-flop synchronizer.
  - A falling edge starts a bit timer. At CLKS_PER_BIT/2 the start bit is rechecked; if high, it is a glitch and the receiver returns to idle.
  - 8 data bits are sampled LSB first, one every CLKS_PER_BIT, then the stop bit.
  - Stop = 1 gives a 1-cycle byte_valid; stop = 0 gives a 1-cycle frame_err.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, RESTART, ERR.
  - IDLE: CPU_EN=1, BUSY=0. Byte 0xA5 moves to LEN_LO, with CPU_EN=0 and BUSY=1 from the next cycle. Other bytes and frame errors are ignored.
  - LEN_LO/LEN_HI: latch N.
    - N=0 goes to RESTART.
    - N > 2^ADDR_W goes to ERR.
    - Otherwise go to DATA with word index 0 and byte index 0.
  - DATA: each byte fills lane [8*k+7:8*k], k = byte index. After byte 3, go to WRITE.
  - WRITE (1 cycle): IMEM_WE=1, IMEM_ADDR=word index, IMEM_WDATA={b3,b2,b1,b0}. Then increment the word index.
    - If the index now equals N, go to RESTART.
    - Otherwise go back to DATA.
  - RESTART (1 cycle): CPU_RESET=1, CPU_EN=0, then go to IDLE. ERROR clears on reaching IDLE.
  - ERR: ERROR=1, CPU_EN=0, BUSY=0. A 0xA5 byte restarts the load (LEN_LO) and clears ERROR.
- Any frame_err in LEN_LO, LEN_HI or DATA goes to ERR.
- Word index is ADDR_W+1 bits wide, so N = 2^ADDR_W is legal. IMEM_ADDR carries the low ADDR_W bits.

## Timing
- RX edge to byte_valid: 2 synchronizer cycles + ≈9.5 bit periods.
- Last data byte_valid to IMEM_WE: 1 cycle. IMEM_WE to CPU_RESET: 1 cycle. CPU_EN returns to 1 in the cycle after CPU_RESET.
- IMEM_ADDR/IMEM_WDATA hold their last value outside WRITE. Only IMEM_WE qualifies them.
- Each byte takes ~10 bit periods, so WRITE/RESTART never collide with byte_valid. No input buffering is required.
- RESET mid-load: the FSM returns to IDLE with CPU_EN=1. The receiver aborts the current byte. Partially written memory is left as is.

## Structure
- Shared package `loader_pkg`: SYNC_BYTE = 8'hA5, FSM state encoding, and the CLKS_PER_BIT derivation.
- Sub-module `uart_rx`: synchronizer, bit timer, and shift register. Outputs are rx_data[7:0], byte_valid and frame_err. `uart_prog_loader` holds the protocol FSM and the counters.

## Test plan
All scenarios use CLK_FREQ=1_000_000, BAUD=100_000 (CLKS_PER_BIT=10) and ADDR_W=4.
- Nominal load: send A5 02 00 13 05 50 00 93 05 A0 00. Required response:
  - IMEM_WE at addr 0 with 0x00500513, then at addr 1 with 0x00A00593.
  - One CPU_RESET pulse.
  - CPU_EN low from sync+1 until after RESTART.
- Zero length: A5 00 00 → no IMEM_WE, one CPU_RESET pulse, back to IDLE.
- Oversize: A5 11 00 (N=17 > 16) → ERROR=1, CPU_EN=0. A following nominal load clears ERROR and completes.
- Framing error: drive stop bit low on the 3rd data byte → ERROR=1, no further IMEM_WE, BUSY=0.
- Noise: a 3-cycle low glitch on RX in IDLE, plus non-A5 bytes (0x00, 0xFF) → no state change, CPU_EN stays 1.
- Reset mid-load: assert RESET after 5 data bytes → all outputs at reset values next cycle. A fresh load then succeeds starting at addr 0.
